// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with RISC-V load/store sizing, alignment faults
// and a fixed, parameterised response latency.
module data_mem_ctrl #(
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_ready;
    logic        r_done;
    logic        r_fault;
    logic [31:0] r_rdata;
    logic [31:0] r_pend_rdata;
    logic        r_pend_fault;
    logic [31:0] r_mem [DEPTH];

    logic                 w_accept;
    logic                 w_fault;
    logic [ADDR_BITS-1:0] w_idx;
    logic [3:0]           w_be;
    logic [31:0]          w_wlanes;
    logic [31:0]          w_word;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_load;
    logic                 w_unused_addr;

    // Upper address bits wrap modulo depth.
    assign w_idx         = address[ADDR_BITS+1:2];
    assign w_unused_addr = &{1'b0, address[31:ADDR_BITS+2]};
    assign w_word        = r_mem[w_idx];
    assign w_accept      = req && r_ready && (r_state == S_IDLE) && reset;

    always_comb begin
        w_fault = 1'b0;
        case (funct3)
            3'd0:       w_fault = 1'b0;
            3'd1:       w_fault = address[0];
            3'd2:       w_fault = |address[1:0];
            3'd4, 3'd5: w_fault = we | (funct3[0] & address[0]);
            default:    w_fault = 1'b1;
        endcase
    end

    always_comb begin
        w_be     = '0;
        w_wlanes = '0;
        case (funct3[1:0])
            2'd0: begin
                w_be     = 4'b0001 << address[1:0];
                w_wlanes = {4{wdata[7:0]}};
            end
            2'd1: begin
                w_be     = address[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{wdata[15:0]}};
            end
            default: begin
                w_be     = '1;
                w_wlanes = wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = 8'(w_word >> {address[1:0], 3'b000});
        w_half = address[1] ? w_word[31:16] : w_word[15:0];
        w_load = '0;
        case (funct3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd2:    w_load = w_word;
            3'd4:    w_load = {24'd0, w_byte};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = '0;
        endcase
    end

    // Stores commit at the accept edge, so a later reset cannot undo them.
    always_ff @(posedge clock) begin
        if (w_accept && we && !w_fault) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_rdata      <= '0;
            r_pend_rdata <= '0;
            r_pend_fault <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready      <= 1'b0;
                        r_pend_fault <= w_fault;
                        r_pend_rdata <= (we || w_fault) ? '0 : w_load;
                        r_cnt        <= 4'(WAIT_STATES);
                        r_state      <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= '0;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b1;
                    r_fault <= r_pend_fault;
                    r_rdata <= r_pend_rdata;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign rdata = r_rdata;
    assign fault = r_fault;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, meaning word-index width; depth = 2**ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 0, meaning extra cycles between accept and response (0..15).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  access request, sampled only while ready=1.
REQ-006 SHALL have port we  input  1  1=store, 0=load; qualified by req.
REQ-007 SHALL have port funct3  input  3  RISC-V size code: 0 b, 1 h, 2 w, 4 bu, 5 hu.
REQ-008 SHALL have port address  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port ready  output  1  high only in IDLE; request accepted when req&ready at a rising edge.
REQ-011 SHALL have port done  output  1  one-cycle response pulse for every accepted request.
REQ-012 SHALL have port rdata  output  32  load result, valid while done=1 for a non-faulting load.
REQ-013 SHALL have port fault  output  1  high with done when the accepted access was misaligned or illegal.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT (when WAIT_STATES>0) -> RESP -> IDLE; with WAIT_STATES=0, IDLE -> RESP -> IDLE.
REQ-015 SHALL, on accept at edge T, assert done for exactly the cycle after edge T+1+WAIT_STATES; ready=0 from edge T until return to IDLE.
REQ-016 SHALL use a down-counter loaded with WAIT_STATES on accept, leaving WAIT when it reaches 0.
REQ-017 SHALL form word index = address[ADDR_BITS+1:2]; address bits above ADDR_BITS+1 ignored (wrap-around modulo depth).
REQ-018 SHALL fault: h/hu with address[0]=1; w with address[1:0]!=0; loads with funct3 in {3,6,7}; stores with funct3 not in {0,1,2}.
REQ-019 SHALL, for a faulting access, leave memory unchanged, drive rdata=0, and still complete with done after the normal latency.
REQ-020 SHALL commit stores at the accept edge with byte lanes: sb lane address[1:0] <- wdata[7:0]; sh lanes {address[1],0..1} <- wdata[15:0]; sw all four lanes; other lanes untouched.
REQ-021 SHALL sample the addressed word for loads at the accept edge and hold it through WAIT.
REQ-022 SHALL extract loads from the byte/halfword selected by address[1:0]: lb/lh sign-extend, lbu/lhu zero-extend, lw unmodified.
REQ-023 SHALL drive rdata=0 for stores and whenever done=0; fault=0 whenever done=0.
REQ-024 SHALL ignore req, we, funct3, address and wdata while ready=0.
REQ-025 SHALL make a store followed by a load to the same word return the stored data (no stale read).

Reset
REQ-026 SHALL, while reset=0, force state IDLE, counter 0, done=0, fault=0, rdata=0, ready=1.
REQ-027 SHALL, on reset mid-operation, abort with no done pulse; a store already accepted remains committed.
REQ-028 SHALL not clear memory on reset; simulation initial contents are all zero.

Verification
REQ-029 SHALL cover: WAIT_STATES=0, sw 0xDEADBEEF @0x10, then lw @0x10 -> done one cycle after each accept, rdata=0xDEADBEEF, fault=0.
REQ-030 SHALL cover: after REQ-029, sb 0x7F @0x13, lb @0x13 -> 0x0000007F; sb 0x80 @0x12, lb @0x12 -> 0xFFFFFF80, lbu @0x12 -> 0x00000080, lw @0x10 -> 0x7F80BEEF.
REQ-031 SHALL cover: sh 0x8001 @0x22, lh @0x22 -> 0xFFFF8001, lhu -> 0x00008001; lh @0x21 -> fault=1, rdata=0; sw @0x22 -> fault=1, lw @0x20 -> 0x80010000.
REQ-032 SHALL cover: WAIT_STATES=3, lw accepted at edge T -> ready=0, done high only in cycle after edge T+4; req held high during wait ignored.
REQ-033 SHALL cover: ADDR_BITS=12, sw 0x12345678 @0x4008, lw @0x0008 -> 0x12345678 (wrap).
REQ-034 SHALL cover: WAIT_STATES=3, sw 0x55 @0x40 accepted, reset=0 one cycle later -> done never asserted, ready=1 during reset; after release lw @0x40 -> 0x00000055.
